// File: rtl/acia_tx_fifo.sv
// Buffered ACIA transmitter: byte FIFO feeding a per-frame configurable
// serialiser (5-8 data bits, optional even/odd parity, 1 or 2 stop bits).
module acia_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          pclk,
    input  logic [DIV_W-1:0]              div,
    input  logic [1:0]                    data_bits,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop2,
    input  logic [7:0]                    wr_dat,
    input  logic                          wr_en,
    input  logic                          clr_ovr,
    output logic                          tx_serial,
    output logic                          tx_busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [1:0]       nbits_q, nbits_d;
    logic             par_en_q, par_en_d, par_q, par_d, stop2_q, stop2_d;
    logic             tx_q, tx_d, busy_q, busy_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d, empty_q, empty_d, ovr_q, ovr_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic             wr_acc, pop;

    // Parity covers only the active data bits; bits above N-1 are masked off.
    function automatic logic calc_parity(input logic [7:0] b, input logic [1:0] nb,
                                         input logic odd);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - nb);
        return (^(b & mask)) ^ odd;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        nbits_d  = nbits_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        div_d    = div_q;
        pop      = 1'b0;

        if (pclk) begin
            if (state_q == IDLE) begin
                pop = !empty_q;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - DIV_W'(1);
            end else begin
                cnt_d = div_q;
                case (state_q)
                    START: begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                    end
                    DATA: begin
                        if (bit_q == 3'd4 + {1'b0, nbits_q}) begin
                            state_d = par_en_q ? PARITY : STOP;
                            bit_d   = 3'd0;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                    PARITY: begin
                        state_d = STOP;
                        bit_d   = 3'd0;
                    end
                    STOP: begin
                        if (stop2_q && bit_q == 3'd0) begin
                            bit_d = 3'd1;
                        end else if (!empty_q) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            // A pop (from IDLE or straight out of the last stop bit) starts a new frame.
            if (pop) begin
                state_d  = START;
                shreg_d  = mem_q[rd_ptr_q];
                nbits_d  = data_bits;
                par_en_d = parity_en;
                par_d    = calc_parity(mem_q[rd_ptr_q], data_bits, parity_odd);
                stop2_d  = stop2;
                div_d    = div;
                cnt_d    = div;
                bit_d    = 3'd0;
            end
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[bit_d];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);

        wr_acc   = wr_en && !full_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(wr_acc) - LW'(pop);
        full_d   = (level_d == LW'(FIFO_DEPTH));
        empty_d  = (level_d == '0);

        ovr_d = ovr_q;
        if (clr_ovr) ovr_d = 1'b0;
        if (wr_en && full_q) ovr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovr_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovr_q    <= ovr_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q  <= shreg_d;
        nbits_q  <= nbits_d;
        par_en_q <= par_en_d;
        par_q    <= par_d;
        stop2_q  <= stop2_d;
        div_q    <= div_d;
        if (wr_acc) mem_q[wr_ptr_q] <= wr_dat;
    end

    assign tx_serial = tx_q;
    assign tx_busy   = busy_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign level     = level_q;
    assign ovr       = ovr_q;
endmodule

// File: tb/tb_acia_tx_fifo.sv
// Bench for acia_tx_fifo: per-tick line levels compared against frames
// built from the framing rules (start, N data LSB-first, parity, stops).
module tb_acia_tx_fifo;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n, pclk, parity_en, parity_odd, stop2, wr_en, clr_ovr;
    logic [DW-1:0] div;
    logic [1:0]    data_bits;
    logic [7:0]    wr_dat;
    logic          tx_serial, tx_busy, full, empty, ovr;
    logic [LW-1:0] level;

    int   vectors = 0;
    int   miscompares = 0;
    bit   cap_en = 1'b0;
    logic got_tx[$], got_busy[$], exp_tx[$], exp_busy[$];

    acia_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .pclk(pclk), .div(div),
        .data_bits(data_bits), .parity_en(parity_en), .parity_odd(parity_odd),
        .stop2(stop2), .wr_dat(wr_dat), .wr_en(wr_en), .clr_ovr(clr_ovr),
        .tx_serial(tx_serial), .tx_busy(tx_busy), .full(full), .empty(empty),
        .level(level), .ovr(ovr)
    );

    always #5 clk = ~clk;

    // Record line state after every pclk tick; between ticks the line must hold.
    always @(posedge clk) begin
        logic p, t0, b0;
        p  = pclk;
        t0 = tx_serial;
        b0 = tx_busy;
        #1;
        if (cap_en) begin
            if (p) begin
                got_tx.push_back(tx_serial);
                got_busy.push_back(tx_busy);
            end else begin
                vectors++;
                if (tx_serial !== t0 || tx_busy !== b0) begin
                    miscompares++;
                    $display("FAIL hold_no_pclk: tx=%b busy=%b, required tx=%b busy=%b",
                             tx_serial, tx_busy, t0, b0);
                end
            end
        end
    end

    function automatic void add_frame(input logic [7:0] b, input int n, input bit pen,
                                      input bit podd, input bit s2, input int dv);
        int seq[$];
        int ones = 0;
        seq.push_back(0);
        for (int i = 0; i < n; i++) begin
            seq.push_back(int'(b[i]));
            ones += int'(b[i]);
        end
        if (pen) seq.push_back((ones % 2) ^ int'(podd));
        seq.push_back(1);
        if (s2) seq.push_back(1);
        foreach (seq[i])
            for (int r = 0; r <= dv; r++) begin
                exp_tx.push_back(seq[i][0]);
                exp_busy.push_back(1'b1);
            end
    endfunction

    function automatic void add_idle(input int k);
        for (int i = 0; i < k; i++) begin
            exp_tx.push_back(1'b1);
            exp_busy.push_back(1'b0);
        end
    endfunction

    task automatic push(input logic [7:0] b, input logic clr);
        @(negedge clk);
        wr_dat  = b;
        wr_en   = 1'b1;
        clr_ovr = clr;
        @(negedge clk);
        wr_en   = 1'b0;
        clr_ovr = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic pe, input logic po,
                           input logic s2, input int dv);
        data_bits  = db;
        parity_en  = pe;
        parity_odd = po;
        stop2      = s2;
        div        = DW'(dv);
    endtask

    // mode 1: pclk every clk; mode 2: every second clk. Runs until all expected ticks seen.
    task automatic run_capture(input int mode);
        int cnt = 0;
        int n = exp_tx.size();
        got_tx.delete();
        got_busy.delete();
        cap_en = 1'b1;
        for (int k = 0; k < 4 * n + 20; k++) begin
            @(negedge clk);
            if (got_tx.size() >= n) break;
            pclk = (mode == 1) || (cnt % 2 == 1);
            cnt++;
        end
        pclk   = 1'b0;
        cap_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (tx_serial !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx_serial); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
        vectors++; if (level !== LW'(0)) begin miscompares++; $display("FAIL reset_level: got %0d want 0", level); end
        vectors++; if (ovr !== 1'b0) begin miscompares++; $display("FAIL reset_ovr: got %b want 0", ovr); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_8n1_baseline();
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 3);
        push(8'h55, 1'b0);
        vectors++;
        if (level !== LW'(1) || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL 8n1_level: level=%0d empty=%b, want 1/0", level, empty);
        end
        exp_tx.delete(); exp_busy.delete();
        add_frame(8'h55, 8, 0, 0, 0, 3);
        add_idle(4);
        run_capture(1);
        for (int i = 0; i < exp_tx.size(); i++) begin
            vectors++;
            if (got_tx[i] !== exp_tx[i] || got_busy[i] !== exp_busy[i]) begin
                miscompares++;
                $display("FAIL 8n1 tick %0d: tx=%b busy=%b, want tx=%b busy=%b",
                         i, got_tx[i], got_busy[i], exp_tx[i], exp_busy[i]);
            end
        end
    endtask

    task automatic test_7e1();
        for (int po = 0; po < 2; po++) begin
            set_cfg(2'b10, 1'b1, po[0], 1'b0, 1);
            push(8'hC1, 1'b0);
            exp_tx.delete(); exp_busy.delete();
            add_frame(8'hC1, 7, 1, po[0], 0, 1);
            add_idle(3);
            run_capture(1);
            for (int i = 0; i < exp_tx.size(); i++) begin
                vectors++;
                if (got_tx[i] !== exp_tx[i] || got_busy[i] !== exp_busy[i]) begin
                    miscompares++;
                    $display("FAIL 7p1 odd=%0d tick %0d: tx=%b busy=%b, want tx=%b busy=%b",
                             po, i, got_tx[i], got_busy[i], exp_tx[i], exp_busy[i]);
                end
            end
        end
    endtask

    task automatic test_5o2();
        set_cfg(2'b00, 1'b1, 1'b1, 1'b1, 0);
        push(8'h1F, 1'b0);
        exp_tx.delete(); exp_busy.delete();
        add_frame(8'h1F, 5, 1, 1, 1, 0);
        add_idle(3);
        run_capture(1);
        for (int i = 0; i < exp_tx.size(); i++) begin
            vectors++;
            if (got_tx[i] !== exp_tx[i] || got_busy[i] !== exp_busy[i]) begin
                miscompares++;
                $display("FAIL 5o2 tick %0d: tx=%b busy=%b, want tx=%b busy=%b",
                         i, got_tx[i], got_busy[i], exp_tx[i], exp_busy[i]);
            end
        end
    endtask

    task automatic test_overflow_b2b();
        logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 0);
        foreach (bytes[i]) push(bytes[i], 1'b0);
        vectors++;
        if (level !== LW'(4) || full !== 1'b1 || ovr !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_flags: level=%0d full=%b ovr=%b, want 4/1/1", level, full, ovr);
        end
        push(8'h66, 1'b1);
        vectors++;
        if (ovr !== 1'b1) begin miscompares++; $display("FAIL ovf_clr_vs_drop: ovr=%b want 1", ovr); end
        exp_tx.delete(); exp_busy.delete();
        for (int i = 0; i < 4; i++) add_frame(bytes[i], 8, 0, 0, 0, 0);
        add_idle(5);
        run_capture(1);
        for (int i = 0; i < exp_tx.size(); i++) begin
            vectors++;
            if (got_tx[i] !== exp_tx[i] || got_busy[i] !== exp_busy[i]) begin
                miscompares++;
                $display("FAIL b2b tick %0d: tx=%b busy=%b, want tx=%b busy=%b",
                         i, got_tx[i], got_busy[i], exp_tx[i], exp_busy[i]);
            end
        end
        vectors++;
        if (level !== LW'(0) || empty !== 1'b1 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: level=%0d empty=%b full=%b, want 0/1/0", level, empty, full);
        end
        @(negedge clk); clr_ovr = 1'b1;
        @(negedge clk); clr_ovr = 1'b0;
        vectors++;
        if (ovr !== 1'b0) begin miscompares++; $display("FAIL ovr_clear: ovr=%b want 0", ovr); end
    endtask

    task automatic test_half_rate();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1);
        push(b, 1'b0);
        exp_tx.delete(); exp_busy.delete();
        add_frame(b, 8, 0, 0, 0, 1);
        add_idle(3);
        fork
            run_capture(2);
            begin
                repeat (12) @(negedge clk);
                data_bits = 2'b00;
                repeat (20) @(negedge clk);
                data_bits = 2'b11;
            end
        join
        for (int i = 0; i < exp_tx.size(); i++) begin
            vectors++;
            if (got_tx[i] !== exp_tx[i] || got_busy[i] !== exp_busy[i]) begin
                miscompares++;
                $display("FAIL half_rate tick %0d: tx=%b busy=%b, want tx=%b busy=%b",
                         i, got_tx[i], got_busy[i], exp_tx[i], exp_busy[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int bad = 0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 3);
        push(8'hA5, 1'b0);
        push(8'h3C, 1'b0);
        repeat (10) begin @(negedge clk); pclk = 1'b1; end
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || level !== LW'(0) || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL midframe_reset: tx=%b busy=%b level=%0d empty=%b, want 1/0/0/1",
                     tx_serial, tx_busy, level, empty);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        pclk = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL after_reset_quiet: %0d active cycles, want 0", bad);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n, dv, mode, nb;
            logic pe, po, s2;
            logic [7:0] b;
            nb = $urandom_range(0, 3);
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            dv = $urandom_range(0, 3);
            n = $urandom_range(1, 4);
            mode = $urandom_range(1, 2);
            set_cfg(2'(nb), pe, po, s2, dv);
            exp_tx.delete(); exp_busy.delete();
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom_range(0, 255));
                push(b, 1'b0);
                add_frame(b, nb + 5, pe, po, s2, dv);
            end
            add_idle(3);
            run_capture(mode);
            for (int i = 0; i < exp_tx.size(); i++) begin
                vectors++;
                if (got_tx[i] !== exp_tx[i] || got_busy[i] !== exp_busy[i]) begin
                    miscompares++;
                    $display("FAIL random it%0d tick %0d: tx=%b busy=%b, want tx=%b busy=%b",
                             it, i, got_tx[i], got_busy[i], exp_tx[i], exp_busy[i]);
                end
            end
            vectors++;
            if (empty !== 1'b1 || level !== LW'(0)) begin
                miscompares++;
                $display("FAIL random_drain it%0d: empty=%b level=%0d, want 1/0", it, empty, level);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        pclk    = 1'b0;
        wr_en   = 1'b0;
        clr_ovr = 1'b0;
        wr_dat  = 8'h00;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 0);
        test_reset();
        test_8n1_baseline();
        test_7e1();
        test_5o2();
        test_overflow_b2b();
        test_half_rate();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
